// File: rtl/rvcpu_pkg.sv
// Shared RV32I core definitions: register index type, opcode classes and base opcodes.
package rvcpu;

  typedef logic [4:0] reg_t;

  typedef enum logic [3:0] {
    LUI,
    AUIPC,
    JAL,
    JALR,
    BRANCH,
    LOAD,
    STORE,
    OPIMM,
    OP,
    ILLEGAL
  } opclass_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I classifier: opcode class, sign-extended immediate and
// which register fields the instruction reads or writes.
module rv_imm_gen
  import rvcpu::*;
#(
  parameter int Width = 32
) (
  input  logic [31:0]      instr,
  output opclass_t         op,
  output logic [Width-1:0] imm,
  output logic             use_rs1,
  output logic             use_rs2,
  output logic             writes_rd
);

  logic [31:0] imm32;

  // The 32-bit immediate is already extended from instr[31]; widening keeps the sign.
  always_comb begin
    op        = ILLEGAL;
    imm32     = '0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (instr[6:0])
      OPC_LUI: begin
        op        = LUI;
        imm32     = {instr[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        op        = AUIPC;
        imm32     = {instr[31:12], 12'b0};
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        op        = JAL;
        imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        writes_rd = 1'b1;
      end
      OPC_JALR: begin
        op        = JALR;
        imm32     = {{20{instr[31]}}, instr[31:20]};
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LOAD: begin
        op        = LOAD;
        imm32     = {{20{instr[31]}}, instr[31:20]};
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_OPIMM: begin
        op        = OPIMM;
        imm32     = {{20{instr[31]}}, instr[31:20]};
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        op      = BRANCH;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_STORE: begin
        op      = STORE;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP: begin
        op        = OP;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign imm = Width'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: issues regfile reads on accept, registers the decoded
// packet to line up with regfile's registered read data, and stalls on RAW/WAW.
module decode_stage
  import rvcpu::*;
#(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [Width-1:0] in_pc,
  output reg_t             rs1,
  output logic             rs1_valid,
  output reg_t             rs2,
  output logic             rs2_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_pc,
  output opclass_t         out_op,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [Width-1:0] out_imm,
  output reg_t             out_rd,
  output logic             out_rd_valid,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_illegal,
  input  logic             wb_valid,
  input  reg_t             wb_rd,
  input  logic             flush
);

  opclass_t         dec_op;
  logic [Width-1:0] dec_imm;
  logic             dec_use_rs1;
  logic             dec_use_rs2;
  logic             dec_writes_rd;

  rv_imm_gen #(.Width(Width)) u_imm_gen (
    .instr     (in_instr),
    .op        (dec_op),
    .imm       (dec_imm),
    .use_rs1   (dec_use_rs1),
    .use_rs2   (dec_use_rs2),
    .writes_rd (dec_writes_rd)
  );

  reg_t        rs1_f;
  reg_t        rs2_f;
  reg_t        rd_f;
  logic        dec_rd_valid;
  logic        hazard;
  logic        fire;
  logic [31:0] busy;
  logic [31:0] busy_next;

  assign rs1_f        = in_instr[19:15];
  assign rs2_f        = in_instr[24:20];
  assign rd_f         = in_instr[11:7];
  assign dec_rd_valid = dec_writes_rd && (rd_f != 5'd0);

  // No writeback bypass: regfile returns the old value in the same cycle it is written.
  assign hazard = (dec_use_rs1 && busy[rs1_f]) ||
                  (dec_use_rs2 && busy[rs2_f]) ||
                  (dec_rd_valid && busy[rd_f]);

  assign in_ready  = !reset && (!out_valid || out_ready) && !hazard && !flush;
  assign fire      = in_valid && in_ready;
  assign rs1       = reset ? 5'd0 : rs1_f;
  assign rs2       = reset ? 5'd0 : rs2_f;
  assign rs1_valid = fire && dec_use_rs1;
  assign rs2_valid = fire && dec_use_rs2;

  // A new writer's set is applied last so it wins over a same-cycle clear.
  always_comb begin
    busy_next = busy;
    if (wb_valid && (wb_rd != 5'd0))
      busy_next[wb_rd] = 1'b0;
    if (flush && out_valid && !out_ready && out_rd_valid)
      busy_next[out_rd] = 1'b0;
    if (fire && dec_rd_valid)
      busy_next[rd_f] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= '0;
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= opclass_t'(4'd0);
      out_funct3   <= '0;
      out_funct7b5 <= 1'b0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_rd_valid <= 1'b0;
      out_use_rs1  <= 1'b0;
      out_use_rs2  <= 1'b0;
      out_illegal  <= 1'b0;
    end else begin
      busy <= busy_next;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire) begin
        out_valid    <= 1'b1;
        out_pc       <= in_pc;
        out_op       <= dec_op;
        out_funct3   <= in_instr[14:12];
        out_funct7b5 <= in_instr[30];
        out_imm      <= dec_imm;
        out_rd       <= dec_writes_rd ? rd_f : 5'd0;
        out_rd_valid <= dec_rd_valid;
        out_use_rs1  <= dec_use_rs1;
        out_use_rs2  <= dec_use_rs2;
        out_illegal  <= (dec_op == ILLEGAL);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode stage directly upstream of regfile.
- Accepts fetched instructions over a valid/ready handshake and extracts register indices and sign-extended immediates.
- Issues rs1/rs2 read requests to regfile in the accept cycle and presents the decoded packet one cycle later, aligned with regfile's registered rd1/rd2.
- Holds a per-register busy scoreboard and stalls intake on RAW/WAW hazards until writeback clears them.

Parameters:
- Width, 32, datapath width for pc and immediate; instruction word is always 32 bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  fetched instruction valid
- in_ready  output  1  stage accepts instruction this cycle
- in_instr  input  32  instruction word
- in_pc  input  Width  instruction address
- rs1  output  rvcpu::reg_t  regfile read index 1
- rs1_valid  output  1  regfile read enable 1
- rs2  output  rvcpu::reg_t  regfile read index 2
- rs2_valid  output  1  regfile read enable 2
- out_valid  output  1  decoded packet valid (rd1/rd2 valid this cycle)
- out_ready  input  1  execute accepts packet
- out_pc  output  Width  pc of packet
- out_op  output  rvcpu::opclass_t  opcode class
- out_funct3  output  3  funct3
- out_funct7b5  output  1  instr[30]
- out_imm  output  Width  sign-extended immediate
- out_rd  output  rvcpu::reg_t  destination register
- out_rd_valid  output  1  packet writes rd (rd != 0)
- out_use_rs1 / out_use_rs2  output  1 each  packet consumes rd1/rd2
- out_illegal  output  1  unrecognised opcode
- wb_valid  input  1  writeback retiring a register write
- wb_rd  input  rvcpu::reg_t  register being written back
- flush  input  1  squash packet in output register

Behaviour:
- Reset: out_valid=0, all out_* fields=0, rs1=rs2=0, rs1_valid=rs2_valid=0, busy[31:1]=0.
- Opcodes:
  - LUI 0110111 (U), AUIPC 0010111 (U), JAL 1101111 (J): no rs.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011 (I): rs1 only.
  - BRANCH 1100011 (B), STORE 0100011 (S): rs1+rs2, no rd.
  - OP 0110011 (R): rs1+rs2, imm=0.
  - Any other opcode: out_illegal=1, no rs use, no rd, imm=0.
- Immediates are sign-extended from instr[31] to Width.
- Hazard (combinational on decoded in_instr):
  - used rs1 with busy[rs1], or used rs2 with busy[rs2], or rd!=0 with busy[rd].
  - x0 is never busy.
  - No writeback bypass: wb in the same cycle still counts as a hazard, because regfile reads the old value.
- in_ready = (!out_valid || out_ready) && !hazard && !flush, evaluated for the current in_instr.
- fire = in_valid && in_ready.
  - rs1_valid = fire && use_rs1; rs2_valid = fire && use_rs2 (combinational); rs1/rs2 always driven from the instr fields.
  - Edge after fire: output register loaded, out_valid=1. Latency is 1 cycle, matching regfile.
  - If out_valid && !out_ready: packet held; rs*_valid stay 0 so regfile holds rd1/rd2.
  - out_valid && out_ready && !fire: out_valid→0.
- Scoreboard, per edge:
  - Set busy[rd] on fire with rd!=0.
  - Clear busy[wb_rd] on wb_valid with wb_rd!=0.
  - Set and clear of the same reg in the same cycle: set wins.
- flush:
  - out_valid→0.
  - If out_valid && !out_ready && out_rd_valid, clear busy[out_rd] (squashed writer).
  - No fire in the flush cycle.
  - wb_valid still processed.
- Reset mid-operation dominates everything: scoreboard and packet cleared regardless of wb/flush.

Decomposition:
- Shared package rvcpu gains:
  - opclass_t enum: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, ILLEGAL.
  - Opcode localparams.
  - Existing reg_t.
- One combinational sub-module, rv_imm_gen (instr → opclass, imm, use flags), reused later by execute tests.
- Scoreboard and pipeline register stay in decode_stage.

Test Plan:
- Issue read: in_instr=0x00500093 (addi x1,x0,5), pc=0x100, out_ready=1 → same cycle rs1=0, rs1_valid=1, rs2_valid=0. Next cycle out_valid=1, out_op=OPIMM, out_imm=5, out_rd=1, out_rd_valid=1, busy[1]=1.
- RAW stall: after the addi, in_instr=0x002081B3 (add x3,x1,x2) → in_ready=0 until wb_valid=1, wb_rd=1 pulses. in_ready=1 the cycle after; rs1=1, rs2=2 valid on fire.
- Immediates:
  - 0xFE000EE3 (beq x0,x0,-4) → out_imm=0xFFFFFFFC, out_rd_valid=0, use_rs1=use_rs2=1.
  - 0x123452B7 (lui x5) → out_imm=0x12345000.
- Backpressure: out_ready=0 for 3 cycles with a valid packet → in_ready=0, rs*_valid=0, packet stable. out_ready=1 → the next instruction fires that cycle.
- Flush/illegal:
  - Hold packet for addi x1 with out_ready=0, pulse flush → out_valid=0, busy[1]=0.
  - 0x00000000 → out_illegal=1, no reads.
- Collision/reset:
  - fire lui x5 with wb_valid, wb_rd=5 in the same cycle → busy[5]=1.
  - reset mid-stall → out_valid=0, busy all 0, in_ready=1 next cycle.
